// File: rtl/cic_decim_ctrl.sv
// Sequencer for the CIC decimator datapath. It applies the ratio, flushes the
// integrators and combs, generates the decimation strobe, qualifies comb output
// and counts overflow events.
module cic_decim_ctrl #(
  parameter int ORDER = 3,
  parameter int OCW   = 8
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [2:0]     cfg_os_sel,
  input  logic           cfg_valid,
  output logic           cfg_ready,
  input  logic           in_valid,
  output logic [2:0]     int_os_sel,
  output logic           int_clr,
  output logic           dec_strobe,
  output logic           out_valid,
  input  logic           ovf_flag,
  input  logic           ovf_clr,
  output logic           ovf_sticky,
  output logic [OCW-1:0] ovf_cnt
);

  localparam int FW = $clog2(ORDER + 2);
  localparam int SW = (ORDER > 1) ? $clog2(ORDER + 1) : 1;

  typedef enum logic [1:0] {IDLE, FLUSH, SETTLE, RUN} state_t;

  state_t        state, state_nxt;
  logic [FW-1:0] flush_cnt;
  logic [SW-1:0] settle_cnt;
  logic [5:0]    dec_cnt, dec_last;
  logic          active, accept;

  // R-1 for the applied code; code 0 gives R=1, so the terminal count is 0
  assign dec_last = 6'((7'd1 << int_os_sel) - 7'd1);

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    cfg_ready  = (state != FLUSH);
    int_clr    = (state == FLUSH);
    active     = (state == SETTLE) || (state == RUN);
    accept     = cfg_valid && cfg_ready;
    dec_strobe = active && in_valid && (dec_cnt == dec_last);
    out_valid  = (state == RUN) && dec_strobe;
    case (state)
      FLUSH:   if (flush_cnt == FW'(ORDER)) state_nxt = SETTLE;
      SETTLE:  if (dec_strobe && settle_cnt == SW'(ORDER - 1)) state_nxt = RUN;
      default: state_nxt = state;
    endcase
    // A new request overrides progress; the current strobe is still issued
    if (accept) state_nxt = FLUSH;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      int_os_sel <= '0;
      flush_cnt  <= '0;
      settle_cnt <= '0;
      dec_cnt    <= '0;
      ovf_sticky <= 1'b0;
      ovf_cnt    <= '0;
    end else begin
      if (accept) int_os_sel <= (cfg_os_sel == 3'd7) ? 3'd0 : cfg_os_sel;

      flush_cnt <= (state == FLUSH) ? flush_cnt + FW'(1) : '0;

      if (accept || state != SETTLE) settle_cnt <= '0;
      else if (dec_strobe)           settle_cnt <= settle_cnt + SW'(1);

      if (accept || !active) dec_cnt <= '0;
      else if (in_valid)     dec_cnt <= dec_strobe ? 6'd0 : dec_cnt + 6'd1;

      // Flag sampling outside SETTLE/RUN would count int_clr transients
      if (active && ovf_flag) begin
        ovf_sticky <= 1'b1;
        if (ovf_clr)       ovf_cnt <= OCW'(1);
        else if (!(&ovf_cnt)) ovf_cnt <= ovf_cnt + OCW'(1);
      end else if (ovf_clr) begin
        ovf_sticky <= 1'b0;
        ovf_cnt    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_cic_decim_ctrl.sv
// Self-checking bench for cic_decim_ctrl. A phase/sample-count reference model
// predicts every output each cycle under directed and randomized stimulus.
module tb_cic_decim_ctrl;
  localparam int ORDER = 3;
  localparam int OCW   = 8;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic [2:0]     cfg_os_sel = '0;
  logic           cfg_valid = 1'b0;
  logic           cfg_ready;
  logic           in_valid = 1'b0;
  logic [2:0]     int_os_sel;
  logic           int_clr, dec_strobe, out_valid;
  logic           ovf_flag = 1'b0, ovf_clr = 1'b0;
  logic           ovf_sticky;
  logic [OCW-1:0] ovf_cnt;

  int n_cmp = 0;
  int n_err = 0;

  cic_decim_ctrl #(.ORDER(ORDER), .OCW(OCW)) dut (
    .clk(clk), .reset_n(reset_n), .cfg_os_sel(cfg_os_sel), .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready), .in_valid(in_valid), .int_os_sel(int_os_sel),
    .int_clr(int_clr), .dec_strobe(dec_strobe), .out_valid(out_valid),
    .ovf_flag(ovf_flag), .ovf_clr(ovf_clr), .ovf_sticky(ovf_sticky), .ovf_cnt(ovf_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: phase 0 idle, 1 flushing, 2 collecting samples
  int m_phase = 0, m_code = 0, m_flush_left = 0, m_nsamp = 0, m_nstrobe = 0;
  int m_sticky = 0, m_ocnt = 0;
  bit chk_en = 0;
  int total_strobes = 0, total_qual = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic rn, input logic cv, input logic [2:0] cs,
                      input logic iv, input logic of, input logic oc);
    int r;
    bit e_ready, e_clr, e_strobe, e_ov, acc;
    @(negedge clk);
    reset_n = rn; cfg_valid = cv; cfg_os_sel = cs; in_valid = iv;
    ovf_flag = of; ovf_clr = oc;
    #1;
    r        = 1 << m_code;
    e_ready  = (m_phase != 1);
    e_clr    = (m_phase == 1);
    e_strobe = (m_phase == 2) && iv && ((m_nsamp % r) == r - 1);
    e_ov     = e_strobe && (m_nstrobe >= ORDER);
    if (chk_en) begin
      chk("cfg_ready", 32'(cfg_ready), 32'(e_ready));
      chk("int_clr", 32'(int_clr), 32'(e_clr));
      chk("dec_strobe", 32'(dec_strobe), 32'(e_strobe));
      chk("out_valid", 32'(out_valid), 32'(e_ov));
      chk("int_os_sel", 32'(int_os_sel), 32'(m_code));
      chk("ovf_sticky", 32'(ovf_sticky), 32'(m_sticky));
      chk("ovf_cnt", 32'(ovf_cnt), 32'(m_ocnt));
    end
    if (e_strobe) total_strobes++;
    if (e_ov) total_qual++;
    @(posedge clk);
    if (!rn) begin
      m_phase = 0; m_code = 0; m_flush_left = 0; m_nsamp = 0; m_nstrobe = 0;
      m_sticky = 0; m_ocnt = 0;
      chk_en = 1;
    end else begin
      if (m_phase == 2 && of) begin
        m_sticky = 1;
        m_ocnt = oc ? 1 : ((m_ocnt < (1 << OCW) - 1) ? m_ocnt + 1 : m_ocnt);
      end else if (oc) begin
        m_sticky = 0; m_ocnt = 0;
      end
      acc = cv && e_ready;
      if (acc) begin
        m_code = (cs == 3'd7) ? 0 : int'(cs);
        m_phase = 1; m_flush_left = ORDER + 1; m_nsamp = 0; m_nstrobe = 0;
      end else if (m_phase == 1) begin
        m_flush_left--;
        if (m_flush_left == 0) m_phase = 2;
      end else if (m_phase == 2 && iv) begin
        m_nsamp++;
        if (e_strobe) m_nstrobe++;
      end
    end
  endtask

  initial begin
    int guard;
    // Reset
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1, 0);
    step(1, 0, 0, 1, 1, 0);   // idle ignores in_valid and ovf_flag
    step(1, 0, 0, 0, 0, 0);

    // os_sel=3, continuous input: 4 flush cycles, strobe each 8th sample
    total_strobes = 0; total_qual = 0;
    step(1, 1, 3'd3, 1, 0, 0);
    repeat (4 + 8 * 6) step(1, 0, 0, 1, 0, 0);
    chk("strobes_r8", 32'(total_strobes), 32'd6);
    chk("qualified_r8", 32'(total_qual), 32'd3);

    // os_sel=7 -> R=1, in_valid with 2-cycle gaps
    step(1, 1, 3'd7, 1, 0, 0);
    for (int i = 0; i < 30; i++) step(1, 0, 0, (i % 3) == 0, 0, 0);
    chk("code7_applied", 32'(int_os_sel), 32'd0);

    // os_sel=1 to RUN, stop mid-count, then switch to os_sel=6
    step(1, 1, 3'd1, 0, 0, 0);
    guard = 0;
    while (!(m_phase == 2 && m_nstrobe >= ORDER + 1 && (m_nsamp % 2) == 1) && guard < 200) begin
      step(1, 0, 0, 1, 0, 0);
      guard++;
    end
    chk("mid_count_reached", 32'(guard < 200), 32'd1);
    total_strobes = 0; total_qual = 0;
    step(1, 1, 3'd6, 1, 0, 0);
    for (int i = 0; i < 380; i++) step(1, 0, 0, 1'($urandom_range(0, 3) != 0), 0, 0);
    chk("r64_strobe_seen", 32'(total_strobes > 0), 32'd1);

    // cfg_valid held through FLUSH, samples and ovf_flag there are dropped
    step(1, 1, 3'd2, 1, 1, 0);
    repeat (6) step(1, 1, 3'd2, 1, 1, 0);
    step(1, 0, 0, 1, 0, 0);
    guard = 0;
    while (m_nstrobe < ORDER + 1 && guard < 200) begin
      step(1, 0, 0, 1, 0, 0);
      guard++;
    end

    // Overflow saturation and set-wins-over-clear
    for (int i = 0; i < 300; i++) step(1, 0, 0, 1'($urandom_range(0, 1)), 1, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("ovf_saturated", 32'(ovf_cnt), 32'd255);
    chk("ovf_sticky_set", 32'(ovf_sticky), 32'd1);
    step(1, 0, 0, 0, 1, 1);
    step(1, 0, 0, 0, 0, 0);
    chk("ovf_set_wins", 32'(ovf_cnt), 32'd1);
    step(1, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 1500; i++)
      step(1, 1'($urandom_range(0, 60) == 0), 3'($urandom_range(0, 7)),
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 5) == 0),
           1'($urandom_range(0, 40) == 0));

    // Reset during FLUSH aborts it
    step(1, 1, 3'd5, 1, 0, 0);
    step(1, 0, 0, 1, 1, 0);
    step(0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 1, 0, 0);
    chk("rst_int_clr", 32'(int_clr), 32'd0);
    chk("rst_os_sel", 32'(int_os_sel), 32'd0);
    step(1, 0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
